simple_io_port: RTL and testbench
=================================

Name: simple_io_port

Overview:
- CPU-facing I/O responder for the SIMPLE processor: the target side of the controller's IN/OUT instructions.
- OUT words from the CPU are buffered in an output FIFO and drained to an external sink over valid/ready.
- Words from an external source are buffered in an input FIFO and returned to the CPU through an IN request/acknowledge handshake.
- Sits between the controller's I/O path and board-level peripherals (switches, LEDs, host link).

Parameters:
- DATA_W, 16, word width on every data port.
- OUT_DEPTH, 4, output FIFO entries (power of two, >=2).
- IN_DEPTH, 4, input FIFO entries (power of two, >=2).

Ports:
- clock  in  1  single system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- cpu_out_valid  in  1  CPU presents an OUT word this cycle.
- cpu_out_data  in  DATA_W  OUT word.
- cpu_out_ready  out  1  output FIFO not full; the word is accepted when valid && ready.
- cpu_in_req  in  1  IN request, level, held until cpu_in_ack.
- cpu_in_ack  out  1  one-cycle pulse; cpu_in_data is valid in this cycle.
- cpu_in_data  out  DATA_W  IN result; holds its last value when ack is low.
- ext_out_valid  out  1  output FIFO non-empty.
- ext_out_data  out  DATA_W  head of output FIFO.
- ext_out_ready  in  1  sink accepts the word when valid && ready.
- ext_in_valid  in  1  source presents a word.
- ext_in_data  in  DATA_W  source word.
- ext_in_ready  out  1  input FIFO not full.
- out_count  out  log2(OUT_DEPTH)+1  output FIFO occupancy.
- in_count  out  log2(IN_DEPTH)+1  input FIFO occupancy.

Behaviour:
- Reset (async assert, sync release):
  - All FIFO pointers and counts go to 0 and the FSM goes to IDLE.
  - cpu_in_ack=0, cpu_in_data=0, ext_out_valid=0, cpu_out_ready=1, ext_in_ready=1.
  - FIFO RAM contents are don't-care.
  - Reset mid-handshake discards all buffered words and any pending IN request; no ack is issued.
- Output FIFO:
  - Push on cpu_out_valid && cpu_out_ready. Pop on ext_out_valid && ext_out_ready.
  - ext_out_data is the registered head. A pushed word appears on ext_out_valid one cycle after the push (no same-cycle bypass into an empty FIFO).
  - Push and pop in the same cycle: count is unchanged, legal when full (the pop frees the slot). cpu_out_ready is computed from the registered count only and is low when full, even if a pop occurs that cycle.
  - Pointers wrap modulo OUT_DEPTH.
- Input FIFO: same rules with ext_in_valid/ext_in_ready as push and the IN FSM as pop.
- IN FSM:
  - States: IDLE, WAIT, RESP.
  - IDLE: if cpu_in_req && in_count!=0, go to RESP and pop. If cpu_in_req && empty, go to WAIT.
  - WAIT: when in_count!=0, go to RESP and pop.
  - RESP: cpu_in_ack=1 and cpu_in_data = the popped word (registered); then go to IDLE unconditionally.
  - Latency: ack arrives 1 cycle after the req is sampled when data is available; otherwise 1 cycle after the first word lands in the FIFO.
  - A req still high in the cycle after RESP is a new request, so back-to-back INs are spaced 2 cycles apart.
  - Dropping req while in WAIT returns the FSM to IDLE with no pop.
- Simultaneous external push and FSM pop on the input FIFO follow the same count rule as the output FIFO.
- No data is ever dropped or duplicated. Overflow and underflow are impossible by construction.

Optional Feature:
- Macro: SIMPLE_IO_LOOPBACK_EN.
- When defined, adds input port loopback (1 bit).
- With loopback=1:
  - The output FIFO head drains into the input FIFO instead of the external sink: pop when the input FIFO is not full.
  - ext_out_valid is forced to 0 and ext_in_ready is forced to 0.
- Changing loopback only takes effect on word boundaries and never splits a transfer.
- When the macro is undefined: no loopback port, and the external paths behave as described above.

Test Plan:
- Reset, then CPU pushes 0x1234, 0x5678 with ext_out_ready=1 -> ext_out_data shows 0x1234 then 0x5678 on consecutive cycles, each starting 1 cycle after its push; out_count returns to 0.
- ext_out_ready=0 and CPU pushes 5 words with OUT_DEPTH=4 -> cpu_out_ready drops after the 4th push and the 5th is held. Then raise ready -> all 5 words exit in order with no loss.
- cpu_in_req held with an empty input FIFO for 10 cycles, then ext_in pushes 0x00AB -> single ack pulse 1 cycle after the word lands, cpu_in_data=0x00AB, in_count=0.
- Input FIFO preloaded with 0x0001, 0x0002, 0x0003 and req held continuously -> acks every 2nd cycle with data 1, 2, 3, then the FSM sits in WAIT.
- Assert reset while the FSM is in WAIT and 2 words are in the output FIFO -> all outputs at reset values, no ack, and counts stay 0 after release.
- (SIMPLE_IO_LOOPBACK_EN) loopback=1, CPU OUTs 0xBEEF then issues IN -> cpu_in_data=0xBEEF and ext_out_valid stays 0 throughout.

Source files
------------

// File: rtl/simple_io_port.sv
// simple_io_port: I/O responder on the target side of the SIMPLE controller's IN/OUT path.
// The CPU pushes OUT words into an output FIFO, and an external sink drains that FIFO over valid/ready.
// An external source fills an input FIFO, and a small FSM returns those words to the CPU through an
// IN request/acknowledge handshake.
// Optional build macro SIMPLE_IO_LOOPBACK_EN adds a 'loopback' input. When loopback is high, the head
// of the output FIFO is routed into the input FIFO and both external paths are closed.
module simple_io_port #(
    parameter int DATA_W    = 16,
    parameter int OUT_DEPTH = 4,
    parameter int IN_DEPTH  = 4
) (
    input  logic                           clock,
    input  logic                           reset,
`ifdef SIMPLE_IO_LOOPBACK_EN
    input  logic                           loopback,
`endif
    input  logic                           cpu_out_valid,
    input  logic [DATA_W-1:0]              cpu_out_data,
    output logic                           cpu_out_ready,
    input  logic                           cpu_in_req,
    output logic                           cpu_in_ack,
    output logic [DATA_W-1:0]              cpu_in_data,
    output logic                           ext_out_valid,
    output logic [DATA_W-1:0]              ext_out_data,
    input  logic                           ext_out_ready,
    input  logic                           ext_in_valid,
    input  logic [DATA_W-1:0]              ext_in_data,
    output logic                           ext_in_ready,
    output logic [$clog2(OUT_DEPTH):0]     out_count,
    output logic [$clog2(IN_DEPTH):0]      in_count
);

    localparam int OUT_AW = $clog2(OUT_DEPTH);
    localparam int IN_AW  = $clog2(IN_DEPTH);
    localparam logic [OUT_AW:0] OUT_FULL = (OUT_AW+1)'(OUT_DEPTH);
    localparam logic [IN_AW:0]  IN_FULL  = (IN_AW+1)'(IN_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [DATA_W-1:0] out_mem [OUT_DEPTH];
    logic [OUT_AW-1:0] out_wr_ptr;
    logic [OUT_AW-1:0] out_rd_ptr;
    logic [DATA_W-1:0] in_mem [IN_DEPTH];
    logic [IN_AW-1:0]  in_wr_ptr;
    logic [IN_AW-1:0]  in_rd_ptr;

    logic lb_mode;
    logic out_not_empty;
    logic in_not_full;
    logic in_not_empty;
    logic lb_xfer;
    logic out_push;
    logic out_pop;
    logic in_push;
    logic in_pop;
    logic [DATA_W-1:0] in_push_data;

`ifdef SIMPLE_IO_LOOPBACK_EN
    assign lb_mode = loopback;
`else
    assign lb_mode = 1'b0;
`endif

    // Every flag below comes from the registered counts only. As a result, a full FIFO keeps ready
    // low even in a cycle where it also pops.
    assign out_not_empty = (out_count != '0);
    assign in_not_full   = (in_count != IN_FULL);
    assign in_not_empty  = (in_count != '0);

    assign cpu_out_ready = (out_count != OUT_FULL);
    assign ext_out_valid = out_not_empty && !lb_mode;
    assign ext_out_data  = out_mem[out_rd_ptr];
    assign ext_in_ready  = in_not_full && !lb_mode;

    // Every transfer completes in one cycle, so toggling loopback can never split a word.
    assign lb_xfer      = lb_mode && out_not_empty && in_not_full;
    assign out_push     = cpu_out_valid && cpu_out_ready;
    assign out_pop      = lb_mode ? lb_xfer : (ext_out_valid && ext_out_ready);
    assign in_push      = lb_mode ? lb_xfer : (ext_in_valid && ext_in_ready);
    assign in_push_data = lb_mode ? out_mem[out_rd_ptr] : ext_in_data;

    // Output FIFO storage. It has no reset because its contents are don't-care after reset.
    always_ff @(posedge clock) begin
        if (out_push) begin
            out_mem[out_wr_ptr] <= cpu_out_data;
        end
    end

    // Output FIFO pointers and occupancy. The pointers wrap naturally at a power-of-two depth.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_wr_ptr <= '0;
            out_rd_ptr <= '0;
            out_count  <= '0;
        end else begin
            if (out_push) begin
                out_wr_ptr <= out_wr_ptr + 1'b1;
            end
            if (out_pop) begin
                out_rd_ptr <= out_rd_ptr + 1'b1;
            end
            case ({out_push, out_pop})
                2'b10:   out_count <= out_count + 1'b1;
                2'b01:   out_count <= out_count - 1'b1;
                default: out_count <= out_count;
            endcase
        end
    end

    // Input FIFO storage. It is fed either by the external source or by the loopback path.
    always_ff @(posedge clock) begin
        if (in_push) begin
            in_mem[in_wr_ptr] <= in_push_data;
        end
    end

    // Input FIFO pointers and occupancy. The IN FSM is the only reader.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            in_wr_ptr <= '0;
            in_rd_ptr <= '0;
            in_count  <= '0;
        end else begin
            if (in_push) begin
                in_wr_ptr <= in_wr_ptr + 1'b1;
            end
            if (in_pop) begin
                in_rd_ptr <= in_rd_ptr + 1'b1;
            end
            case ({in_push, in_pop})
                2'b10:   in_count <= in_count + 1'b1;
                2'b01:   in_count <= in_count - 1'b1;
                default: in_count <= in_count;
            endcase
        end
    end

    // IN FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // IN FSM next-state logic. The FIFO is popped on the transition into RESP. Dropping the request
    // while in WAIT abandons the request without consuming a word.
    always_comb begin
        state_d = state_q;
        in_pop  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpu_in_req) begin
                    if (in_not_empty) begin
                        in_pop  = 1'b1;
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!cpu_in_req) begin
                    state_d = IDLE;
                end else if (in_not_empty) begin
                    in_pop  = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The IN result is captured when the word is popped and held until the next pop.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cpu_in_data <= '0;
        end else if (in_pop) begin
            cpu_in_data <= in_mem[in_rd_ptr];
        end
    end

    assign cpu_in_ack = (state_q == RESP);

endmodule

// File: tb/tb_simple_io_port.sv
// tb_simple_io_port: directed self-checking bench for simple_io_port.
// It covers the CPU OUT path, output backpressure, a blocking IN request, back-to-back IN requests,
// reset in the middle of a transfer, and loopback when SIMPLE_IO_LOOPBACK_EN is defined.
module tb_simple_io_port;

    localparam int DATA_W = 16;

    logic              clock;
    logic              reset;
`ifdef SIMPLE_IO_LOOPBACK_EN
    logic              loopback;
`endif
    logic              cpu_out_valid;
    logic [DATA_W-1:0] cpu_out_data;
    logic              cpu_out_ready;
    logic              cpu_in_req;
    logic              cpu_in_ack;
    logic [DATA_W-1:0] cpu_in_data;
    logic              ext_out_valid;
    logic [DATA_W-1:0] ext_out_data;
    logic              ext_out_ready;
    logic              ext_in_valid;
    logic [DATA_W-1:0] ext_in_data;
    logic              ext_in_ready;
    logic [2:0]        out_count;
    logic [2:0]        in_count;

    int err_count;
    int check_count;

    simple_io_port #(.DATA_W(16), .OUT_DEPTH(4), .IN_DEPTH(4)) dut (
        .clock         (clock),
        .reset         (reset),
`ifdef SIMPLE_IO_LOOPBACK_EN
        .loopback      (loopback),
`endif
        .cpu_out_valid (cpu_out_valid),
        .cpu_out_data  (cpu_out_data),
        .cpu_out_ready (cpu_out_ready),
        .cpu_in_req    (cpu_in_req),
        .cpu_in_ack    (cpu_in_ack),
        .cpu_in_data   (cpu_in_data),
        .ext_out_valid (ext_out_valid),
        .ext_out_data  (ext_out_data),
        .ext_out_ready (ext_out_ready),
        .ext_in_valid  (ext_in_valid),
        .ext_in_data   (ext_in_data),
        .ext_in_ready  (ext_in_ready),
        .out_count     (out_count),
        .in_count      (in_count)
    );

    // Free-running clock with a 10-time-unit period.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Counts one comparison and reports it if the observed value differs from the expected value.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            err_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drives the CPU OUT channel.
    task automatic applyStimulus(input logic valid, input logic [DATA_W-1:0] data);
        cpu_out_valid = valid;
        cpu_out_data  = data;
    endtask

    // Advances one clock edge, then settles past it before sampling outputs.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Checks every output that has a defined reset value.
    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_ack"},       cpu_in_ack,    1'b0);
        checkOutput({tag, "_in_data"},   cpu_in_data,   16'h0000);
        checkOutput({tag, "_ext_valid"}, ext_out_valid, 1'b0);
        checkOutput({tag, "_out_ready"}, cpu_out_ready, 1'b1);
        checkOutput({tag, "_in_ready"},  ext_in_ready,  1'b1);
        checkOutput({tag, "_out_count"}, out_count,     3'd0);
        checkOutput({tag, "_in_count"},  in_count,      3'd0);
    endtask

    // Main directed sequence.
    initial begin
        logic [DATA_W-1:0] words [5];
        logic [DATA_W-1:0] got [$];
        logic              exp_ack [7];
        logic [DATA_W-1:0] exp_data [7];
        logic [2:0]        exp_cnt [7];
        logic              accepted;
        logic              seen;

        err_count   = 0;
        check_count = 0;
        reset       = 1'b1;
`ifdef SIMPLE_IO_LOOPBACK_EN
        loopback    = 1'b0;
`endif
        applyStimulus(1'b0, '0);
        cpu_in_req    = 1'b0;
        ext_out_ready = 1'b0;
        ext_in_valid  = 1'b0;
        ext_in_data   = '0;

        // Reset values.
        tick();
        tick();
        checkResetValues("rst");
        reset = 1'b0;
        tick();

        // Two OUT words stream straight through to a ready sink.
        $display("[TB] OUT passthrough");
        ext_out_ready = 1'b1;
        checkOutput("t1_valid_pre", ext_out_valid, 1'b0);
        applyStimulus(1'b1, 16'h1234);
        tick();
        checkOutput("t1_valid_a", ext_out_valid, 1'b1);
        checkOutput("t1_data_a",  ext_out_data,  16'h1234);
        checkOutput("t1_count_a", out_count,     3'd1);
        applyStimulus(1'b1, 16'h5678);
        tick();
        checkOutput("t1_valid_b", ext_out_valid, 1'b1);
        checkOutput("t1_data_b",  ext_out_data,  16'h5678);
        checkOutput("t1_count_b", out_count,     3'd1);
        applyStimulus(1'b0, '0);
        tick();
        checkOutput("t1_valid_end", ext_out_valid, 1'b0);
        checkOutput("t1_count_end", out_count,     3'd0);

        // The output FIFO fills under backpressure, then drains in order.
        $display("[TB] OUT backpressure");
        words[0] = 16'hA000; words[1] = 16'hA111; words[2] = 16'hA222;
        words[3] = 16'hA333; words[4] = 16'hA444;
        ext_out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checkOutput("t2_ready_fill", cpu_out_ready, 1'b1);
            applyStimulus(1'b1, words[i]);
            tick();
        end
        checkOutput("t2_count_full", out_count,     3'd4);
        checkOutput("t2_ready_full", cpu_out_ready, 1'b0);
        applyStimulus(1'b1, words[4]);
        tick();
        checkOutput("t2_count_held", out_count,     3'd4);
        checkOutput("t2_ready_held", cpu_out_ready, 1'b0);
        ext_out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            accepted = cpu_out_valid && cpu_out_ready;
            seen     = ext_out_valid;
            if (seen) got.push_back(ext_out_data);
            tick();
            if (accepted) applyStimulus(1'b0, '0);
        end
        checkOutput("t2_num_words", got.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < got.size()) checkOutput("t2_word", got[i], words[i]);
        end
        checkOutput("t2_count_end", out_count, 3'd0);
        ext_out_ready = 1'b0;

        // An IN request blocks on an empty FIFO until a word arrives.
        $display("[TB] IN blocking request");
        cpu_in_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput("t3_no_ack", cpu_in_ack, 1'b0);
        end
        ext_in_valid = 1'b1;
        ext_in_data  = 16'h00AB;
        tick();
        ext_in_valid = 1'b0;
        checkOutput("t3_ack_land",   cpu_in_ack, 1'b0);
        checkOutput("t3_count_land", in_count,   3'd1);
        tick();
        checkOutput("t3_ack",       cpu_in_ack,  1'b1);
        checkOutput("t3_data",      cpu_in_data, 16'h00AB);
        checkOutput("t3_count_ack", in_count,    3'd0);
        cpu_in_req = 1'b0;
        tick();
        checkOutput("t3_ack_after",  cpu_in_ack,  1'b0);
        checkOutput("t3_data_hold",  cpu_in_data, 16'h00AB);

        // Back-to-back IN requests against a preloaded FIFO.
        $display("[TB] IN back-to-back");
        for (int i = 1; i <= 3; i++) begin
            ext_in_valid = 1'b1;
            ext_in_data  = 16'(i);
            tick();
        end
        ext_in_valid = 1'b0;
        checkOutput("t4_preload", in_count, 3'd3);
        exp_ack  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        exp_data = '{16'd1, 16'd1, 16'd2, 16'd2, 16'd3, 16'd3, 16'd3};
        exp_cnt  = '{3'd2, 3'd2, 3'd1, 3'd1, 3'd0, 3'd0, 3'd0};
        cpu_in_req = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            checkOutput("t4_ack",   cpu_in_ack,  exp_ack[i]);
            checkOutput("t4_data",  cpu_in_data, exp_data[i]);
            checkOutput("t4_count", in_count,    exp_cnt[i]);
        end

        // Reset while the FSM waits and the output FIFO holds two words.
        $display("[TB] reset mid-handshake");
        applyStimulus(1'b1, 16'hAAAA);
        tick();
        applyStimulus(1'b1, 16'hBBBB);
        tick();
        applyStimulus(1'b0, '0);
        checkOutput("t5_out_count", out_count,     3'd2);
        checkOutput("t5_ext_valid", ext_out_valid, 1'b1);
        reset = 1'b1;
        #1;
        checkResetValues("t5_async");
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("t5_post_ack",   cpu_in_ack,    1'b0);
            checkOutput("t5_post_valid", ext_out_valid, 1'b0);
            checkOutput("t5_post_out",   out_count,     3'd0);
            checkOutput("t5_post_in",    in_count,      3'd0);
        end
        cpu_in_req = 1'b0;
        tick();

`ifdef SIMPLE_IO_LOOPBACK_EN
        // Loopback: an OUT word comes back through IN without appearing externally.
        $display("[TB] loopback");
        loopback      = 1'b1;
        ext_out_ready = 1'b1;
        #1;
        checkOutput("t6_in_ready", ext_in_ready, 1'b0);
        applyStimulus(1'b1, 16'hBEEF);
        tick();
        applyStimulus(1'b0, '0);
        cpu_in_req = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            checkOutput("t6_ext_valid", ext_out_valid, 1'b0);
            tick();
            if (cpu_in_ack) begin
                seen = 1'b1;
                checkOutput("t6_data", cpu_in_data, 16'hBEEF);
            end
        end
        checkOutput("t6_ack_seen", seen, 1'b1);
        cpu_in_req = 1'b0;
        loopback   = 1'b0;
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", err_count, check_count);
        $finish;
    end

endmodule
